spi_master_duplex: RTL and testbench
====================================

SPI_MASTER_DUPLEX -- requirements
Module: spi_master_duplex

Interface
REQ-001 SHALL have parameter SPI_MODE, default 0, meaning SPI mode 0..3 (CPOL = mode 2 or 3; CPHA = mode 1 or 3).
REQ-002 SHALL have parameter CLKS_PER_HALF_BIT, default 2, meaning clk_i cycles per SCLK half period; legal range >=2.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, meaning word length in bits; legal range 4..32.
REQ-004 SHALL have parameter MSB_FIRST, default 1, meaning 1 shifts MSb first and 0 shifts LSb first, on both MOSI and MISO.
REQ-005 SHALL have parameter CS_INACTIVE_CLKS, default 2, meaning minimum clk_i cycles CS stays high between words; legal range >=1.
REQ-006 clk_i  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-007 rst_i  input  1  reset; asynchronous, active-low.
REQ-008 data_i  input  DATA_WIDTH  word to transmit; sampled only on an accepted strobe.
REQ-009 data_in_valid_strobe_i  input  1  one-cycle transmit request.
REQ-010 tx_ready_o  output  1  high when a strobe will be accepted.
REQ-011 data_o  output  DATA_WIDTH  last received word; held until the next word completes.
REQ-012 data_out_valid_strobe_o  output  1  one-cycle pulse when data_o is updated.
REQ-013 spi_clk_o  output  1  SCLK, registered.
REQ-014 spi_mosi_o  output  1  serial data out, registered.
REQ-015 spi_miso_i  input  1  serial data in.
REQ-016 spi_cs_o  output  1  chip select, active-low, registered.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and GAP.
- IDLE: tx_ready_o=1.
- All other states: tx_ready_o=0.
REQ-018 Strobe acceptance:
- A strobe with tx_ready_o=1 SHALL latch data_i into the TX shift register and enter SETUP on the next cycle.
- spi_cs_o SHALL go 0 on that same cycle.
- tx_ready_o SHALL go 0 on that same cycle.
REQ-019 A strobe with tx_ready_o=0 SHALL be ignored, with no change to any state or output.
REQ-020 SETUP SHALL last CLKS_PER_HALF_BIT cycles with SCLK at CPOL.
- If CPHA=0, spi_mosi_o SHALL present the first bit from SETUP entry.
REQ-021 SHIFT SHALL produce exactly 2*DATA_WIDTH SCLK edges, each half period CLKS_PER_HALF_BIT cycles.
- Leading edge = edge away from CPOL.
- SCLK SHALL end at CPOL.
REQ-022 CPHA=0 data timing:
- MISO SHALL be sampled at each leading edge.
- MOSI SHALL advance at each trailing edge, except the last.
REQ-023 CPHA=1 data timing:
- MOSI SHALL present the next bit at each leading edge.
- MISO SHALL be sampled at each trailing edge.
REQ-024 Sampling definition: spi_miso_i SHALL be captured on the clk_i rising edge at which spi_clk_o makes its sampling transition.
REQ-025 RX bits SHALL be assembled into an RX shift register in the order set by MSB_FIRST, so that loopback (MISO=MOSI) returns the transmitted word unchanged.
REQ-026 HOLD SHALL last CLKS_PER_HALF_BIT cycles after the final edge; then:
- spi_cs_o SHALL rise to 1.
- data_o SHALL load the RX register.
- data_out_valid_strobe_o SHALL pulse for exactly 1 cycle.
REQ-027 GAP SHALL last CS_INACTIVE_CLKS cycles with spi_cs_o=1, then return to IDLE with tx_ready_o=1.
REQ-028 Transaction length: tx_ready_o low to tx_ready_o high SHALL be exactly (2*DATA_WIDTH+2)*CLKS_PER_HALF_BIT + CS_INACTIVE_CLKS cycles.
REQ-029 spi_mosi_o SHALL hold its last value outside SHIFT/SETUP and SHALL only change while spi_cs_o=0.
REQ-030 Counters SHALL be sized with clog2 of their maximum value; the edge counter SHALL count down from 2*DATA_WIDTH with no wrap.

Reset
REQ-031 rst_i=0 SHALL immediately and asynchronously force:
- State = IDLE.
- tx_ready_o=0 while in reset, and 1 on the first cycle after release.
- spi_cs_o=1, spi_clk_o=CPOL, spi_mosi_o=0.
- data_o=0, data_out_valid_strobe_o=0.
- All counters and shift registers = 0.
REQ-032 Reset mid-transfer SHALL abort with no data_out_valid_strobe_o pulse; the partial word SHALL be discarded.

Verification
REQ-033 Mode 0, DATA_WIDTH=8, CLKS_PER_HALF_BIT=2, CS_INACTIVE_CLKS=2, MISO looped to MOSI, send 0xA5 -> 16 SCLK edges; MOSI bits 1,0,1,0,0,1,0,1; data_o=0xA5 with one strobe; tx_ready_o low for exactly 38 cycles.
REQ-034 Mode 3, DATA_WIDTH=16, MISO driven by a model returning 0x1234 -> SCLK idles 1; data changes on falling edges; data_o=0x1234; CS high for >=2 cycles before the next word.
REQ-035 MSB_FIRST=0, DATA_WIDTH=8, send 0x01 -> first MOSI bit 1, then seven zeros; loopback data_o=0x01.
REQ-036 Strobe with data 0xFF asserted during SHIFT of 0x00 -> ignored; MOSI all zeros; exactly one data_out_valid_strobe_o pulse.
REQ-037 rst_i low after 5 SCLK edges -> spi_cs_o=1, spi_clk_o=CPOL, spi_mosi_o=0 in the same cycle; no strobe pulse; a new word after release transfers correctly.
REQ-038 Back-to-back: strobe on the first cycle with tx_ready_o=1 -> accepted; CS inactive gap equals CS_INACTIVE_CLKS.

Source files
------------

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master: one word per strobe, all four SPI modes,
// configurable word length, bit order, SCLK rate and CS idle time.
module spi_master_duplex #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int DATA_WIDTH        = 8,
    parameter int MSB_FIRST         = 1,
    parameter int CS_INACTIVE_CLKS  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_in_valid_strobe_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_out_valid_strobe_o,
    output logic                  spi_clk_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i,
    output logic                  spi_cs_o
);

    localparam int W   = DATA_WIDTH;
    localparam int HCW = $clog2(CLKS_PER_HALF_BIT);
    localparam int GCW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
    localparam int ECW = $clog2(2 * DATA_WIDTH + 1);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam logic MSBF = (MSB_FIRST != 0);

    localparam logic [HCW-1:0] H_LAST = HCW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [GCW-1:0] G_LAST = GCW'(CS_INACTIVE_CLKS - 1);
    localparam logic [ECW-1:0] E_ALL  = ECW'(2 * DATA_WIDTH);
    localparam logic [ECW-1:0] E_ONE  = ECW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t         state_q;
    logic [W-1:0]   tx_q;
    logic [W-1:0]   rx_q;
    logic [HCW-1:0] hcnt_q;
    logic [ECW-1:0] ecnt_q;
    logic [GCW-1:0] gcnt_q;
    logic           rdy_q;
    logic [W-1:0]   dout_q;
    logic           dv_q;
    logic           sclk_q;
    logic           mosi_q;
    logic           cs_q;

    function automatic logic head(input logic [W-1:0] x);
        return MSBF ? x[W-1] : x[0];
    endfunction

    function automatic logic [W-1:0] shl(input logic [W-1:0] x);
        return MSBF ? {x[W-2:0], 1'b0} : {1'b0, x[W-1:1]};
    endfunction

    logic [W-1:0] rx_d;
    logic         lead_d;
    logic         last_d;
    logic         sample_d;
    logic         drive_d;

    // Remaining-edge count is even on leading edges (starts at 2*W).
    assign lead_d   = ~ecnt_q[0];
    assign last_d   = (ecnt_q == E_ONE);
    assign sample_d = CPHA ? ~lead_d : lead_d;
    assign drive_d  = CPHA ? lead_d : (~lead_d & ~last_d);
    assign rx_d     = MSBF ? {rx_q[W-2:0], spi_miso_i}
                           : {spi_miso_i, rx_q[W-1:1]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            hcnt_q  <= '0;
            ecnt_q  <= '0;
            gcnt_q  <= '0;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            sclk_q  <= CPOL;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            dv_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (data_in_valid_strobe_i && rdy_q) begin
                        state_q <= SETUP;
                        rdy_q   <= 1'b0;
                        cs_q    <= 1'b0;
                        rx_q    <= '0;
                        hcnt_q  <= H_LAST;
                        ecnt_q  <= E_ALL;
                        if (CPHA) begin
                            tx_q <= data_i;
                        end else begin
                            tx_q   <= shl(data_i);
                            mosi_q <= head(data_i);
                        end
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (hcnt_q == '0) begin
                        state_q <= SHIFT;
                        hcnt_q  <= H_LAST;
                    end else begin
                        hcnt_q <= hcnt_q - 1'b1;
                    end
                end
                SHIFT: begin
                    if (hcnt_q == '0) begin
                        sclk_q <= ~sclk_q;
                        ecnt_q <= ecnt_q - E_ONE;
                        hcnt_q <= H_LAST;
                        if (sample_d) begin
                            rx_q <= rx_d;
                        end
                        if (drive_d) begin
                            mosi_q <= head(tx_q);
                            tx_q   <= shl(tx_q);
                        end
                        if (last_d) begin
                            state_q <= HOLD;
                        end
                    end else begin
                        hcnt_q <= hcnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (hcnt_q == '0) begin
                        state_q <= GAP;
                        cs_q    <= 1'b1;
                        dout_q  <= rx_q;
                        dv_q    <= 1'b1;
                        gcnt_q  <= G_LAST;
                    end else begin
                        hcnt_q <= hcnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt_q == '0) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end else begin
                        gcnt_q <= gcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready_o              = rdy_q;
    assign data_o                  = dout_q;
    assign data_out_valid_strobe_o = dv_q;
    assign spi_clk_o               = sclk_q;
    assign spi_mosi_o              = mosi_q;
    assign spi_cs_o                = cs_q;

endmodule

// File: tb/tb_spi_master_duplex.sv
// Scoreboard bench for spi_master_duplex: mode 0 loopback, mode 3 with
// a slave model, and LSB-first loopback, sharing one clock and reset.
module tb_spi_master_duplex;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // DUT0: mode 0, 8 bit, MSB first, loopback
    logic [7:0]  din0 = '0, dout0;
    logic        stb0 = 1'b0, rdy0, dvs0, sclk0, mosi0, cs0;
    // DUT1: mode 3, 16 bit, slave model on MISO
    logic [15:0] din1 = '0, dout1;
    logic        stb1 = 1'b0, rdy1, dvs1, sclk1, mosi1, cs1;
    logic        miso1 = 1'b0;
    // DUT2: mode 0, 8 bit, LSB first, loopback
    logic [7:0]  din2 = '0, dout2;
    logic        stb2 = 1'b0, rdy2, dvs2, sclk2, mosi2, cs2;

    spi_master_duplex #(.SPI_MODE(0), .DATA_WIDTH(8)) u0 (
        .clk_i(clk), .rst_i(rst_n), .data_i(din0),
        .data_in_valid_strobe_i(stb0), .tx_ready_o(rdy0),
        .data_o(dout0), .data_out_valid_strobe_o(dvs0),
        .spi_clk_o(sclk0), .spi_mosi_o(mosi0),
        .spi_miso_i(mosi0), .spi_cs_o(cs0));

    spi_master_duplex #(.SPI_MODE(3), .DATA_WIDTH(16)) u1 (
        .clk_i(clk), .rst_i(rst_n), .data_i(din1),
        .data_in_valid_strobe_i(stb1), .tx_ready_o(rdy1),
        .data_o(dout1), .data_out_valid_strobe_o(dvs1),
        .spi_clk_o(sclk1), .spi_mosi_o(mosi1),
        .spi_miso_i(miso1), .spi_cs_o(cs1));

    spi_master_duplex #(.SPI_MODE(0), .DATA_WIDTH(8), .MSB_FIRST(0)) u2 (
        .clk_i(clk), .rst_i(rst_n), .data_i(din2),
        .data_in_valid_strobe_i(stb2), .tx_ready_o(rdy2),
        .data_o(dout2), .data_out_valid_strobe_o(dvs2),
        .spi_clk_o(sclk2), .spi_mosi_o(mosi2),
        .spi_miso_i(mosi2), .spi_cs_o(cs2));

    logic [31:0] q_d0[$], q_d1[$], q_d2[$], q_m1[$];
    bit          q_b0[$], q_b2[$];
    bit          mchk0 = 1'b1;

    // Received-word scoreboard
    always @(negedge clk) begin
        if (dvs0) begin
            if (q_d0.size() == 0) chk("dv0_extra", q_d0.size(), 1);
            else chk("dout0", dout0, q_d0.pop_front());
        end
        if (dvs1) begin
            if (q_d1.size() == 0) chk("dv1_extra", q_d1.size(), 1);
            else chk("dout1", dout1, q_d1.pop_front());
        end
        if (dvs2) begin
            if (q_d2.size() == 0) chk("dv2_extra", q_d2.size(), 1);
            else chk("dout2", dout2, q_d2.pop_front());
        end
    end

    // DUT0 MOSI bits, edge count and timing
    logic s0p = 1'b0, c0p = 1'b1, r0p = 1'b0;
    int   e0 = 0, len0 = 0, gap0 = 0, hi0 = 0;
    bit   busy0 = 1'b0, had0 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy0 = 1'b0;
            had0  = 1'b0;
        end else begin
            if (c0p && !cs0) begin
                e0 = 0;
                if (had0) chk("cs0_high_min", hi0 >= 2, 1);
                had0 = 1'b0;
            end
            if (!cs0 && !s0p && sclk0 && mchk0) begin
                if (q_b0.size() == 0) chk("mosi0_extra", q_b0.size(), 1);
                else chk("mosi0_bit", mosi0, q_b0.pop_front());
            end
            if (!cs0 && sclk0 != s0p) e0++;
            if (!c0p && cs0) begin
                chk("sclk0_edges", e0, 16);
                chk("sclk0_end", sclk0, 0);
                hi0  = 0;
                gap0 = 0;
                had0 = 1'b1;
            end
            if (cs0) hi0++;
            if (cs0 && !rdy0) gap0++;
            if (r0p && !rdy0) begin
                busy0 = 1'b1;
                len0  = 0;
            end
            if (!rdy0) len0++;
            if (!r0p && rdy0 && busy0) begin
                chk("rdy0_low_len", len0, 38);
                chk("cs0_gap", gap0, 2);
                busy0 = 1'b0;
            end
        end
        s0p = sclk0;
        c0p = cs0;
        r0p = rdy0;
    end

    // DUT2 MOSI bits (sampled on rising SCLK)
    logic s2p = 1'b0;
    always @(negedge clk) begin
        if (rst_n && !cs2 && !s2p && sclk2) begin
            if (q_b2.size() == 0) chk("mosi2_extra", q_b2.size(), 1);
            else chk("mosi2_bit", mosi2, q_b2.pop_front());
        end
        s2p = sclk2;
    end

    // Mode-3 slave: shifts 0x1234 out on falling, captures on rising
    logic        s1p = 1'b1, c1p = 1'b1, m1p = 1'b0;
    logic [15:0] sl_tx = '0, sl_rx = '0;
    int          bad1 = 0, hi1 = 0;
    bit          had1 = 1'b0;
    always @(negedge clk) begin
        if (c1p && !cs1) begin
            sl_tx = 16'h1234;
            sl_rx = '0;
            if (rst_n && had1) chk("cs1_high_min", hi1 >= 2, 1);
        end
        if (!cs1 && s1p && !sclk1) begin
            miso1 = sl_tx[15];
            sl_tx = sl_tx << 1;
        end
        if (!cs1 && !s1p && sclk1) sl_rx = {sl_rx[14:0], mosi1};
        if (rst_n && mosi1 != m1p && !(s1p && !sclk1)) bad1++;
        if (!rst_n) had1 = 1'b0;
        if (rst_n && !c1p && cs1) begin
            chk("sclk1_idle", sclk1, 1);
            if (q_m1.size() == 0) chk("m1_extra", q_m1.size(), 1);
            else chk("slave_rx1", sl_rx, q_m1.pop_front());
            hi1  = 0;
            had1 = 1'b1;
        end
        if (cs1) hi1++;
        s1p = sclk1;
        c1p = cs1;
        m1p = mosi1;
    end

    function automatic logic rdy_of(input int k);
        case (k)
            0: return rdy0;
            1: return rdy1;
            default: return rdy2;
        endcase
    endfunction

    task automatic wait_rdy(input int k);
        int n = 0;
        while (!rdy_of(k) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy_of(k)) chk("rdy_timeout", rdy_of(k), 1);
    endtask

    task automatic send(input int k, input logic [15:0] d, input bit push);
        wait_rdy(k);
        if (push) begin
            case (k)
                0: begin
                    q_d0.push_back(32'(d[7:0]));
                    for (int i = 7; i >= 0; i--) q_b0.push_back(d[i]);
                end
                1: begin
                    q_d1.push_back(32'h1234);
                    q_m1.push_back(32'(d));
                end
                default: begin
                    q_d2.push_back(32'(d[7:0]));
                    for (int i = 0; i < 8; i++) q_b2.push_back(d[i]);
                end
            endcase
        end
        case (k)
            0: begin din0 = d[7:0]; stb0 = 1'b1; end
            1: begin din1 = d; stb1 = 1'b1; end
            default: begin din2 = d[7:0]; stb2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        stb0 = 1'b0;
        stb1 = 1'b0;
        stb2 = 1'b0;
        chk("accept_rdy_low", rdy_of(k), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int ne, n;
        logic sp;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy0", rdy0, 0);
        chk("rst_cs0", cs0, 1);
        chk("rst_sclk0", sclk0, 0);
        chk("rst_mosi0", mosi0, 0);
        chk("rst_dout0", dout0, 0);
        chk("rst_dv0", dvs0, 0);
        chk("rst_sclk1", sclk1, 1);
        chk("rst_cs1", cs1, 1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rdy0_after_rst", rdy0, 1);

        send(0, 16'h00A5, 1);
        chk("cs0_low_on_accept", cs0, 0);

        // Strobe while shifting 0x00 must be ignored
        send(0, 16'h0000, 1);
        repeat (8) @(posedge clk);
        #1;
        din0 = 8'hFF;
        stb0 = 1'b1;
        @(posedge clk);
        #1;
        stb0 = 1'b0;
        chk("ign_rdy0", rdy0, 0);
        chk("ign_cs0", cs0, 0);

        // Back-to-back words
        send(0, 16'h003C, 1);
        send(0, 16'h00C3, 1);

        // Abort after 5 SCLK edges
        wait_rdy(0);
        mchk0 = 1'b0;
        send(0, 16'h00FF, 0);
        ne = 0;
        n = 0;
        sp = sclk0;
        while (ne < 5 && n < 400) begin
            @(negedge clk);
            n++;
            if (sclk0 != sp) begin
                ne++;
                sp = sclk0;
            end
        end
        if (ne < 5) chk("edge_timeout", ne, 5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_cs0", cs0, 1);
        chk("abort_sclk0", sclk0, 0);
        chk("abort_mosi0", mosi0, 0);
        chk("abort_dv0", dvs0, 0);
        chk("abort_rdy0", rdy0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mchk0 = 1'b1;
        send(0, 16'h0096, 1);
        wait_rdy(0);

        send(1, 16'hBEEF, 1);
        send(1, 16'h0F0F, 1);
        wait_rdy(1);

        send(2, 16'h0001, 1);
        send(2, 16'h0080, 1);
        wait_rdy(2);

        repeat (5) @(posedge clk);
        chk("q_d0_empty", q_d0.size(), 0);
        chk("q_d1_empty", q_d1.size(), 0);
        chk("q_d2_empty", q_d2.size(), 0);
        chk("q_m1_empty", q_m1.size(), 0);
        chk("q_b0_empty", q_b0.size(), 0);
        chk("q_b2_empty", q_b2.size(), 0);
        chk("mosi1_fall_only", bad1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
